// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: turns lw/sw control into a req/ack bus
// transaction, stalls the pipeline until completion, flags misalignment and timeouts.
module mem_access_unit #(
    parameter int          MAX_WAIT = 15,
    parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [31:0] address_in,
    input  logic [31:0] write_data_in,
    output logic [31:0] read_data_out,
    output logic        mem_stall,
    output logic        misaligned,
    output logic        bus_timeout,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic        both_q, both_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        tmo_q, tmo_d;

    logic        acc_s;
    logic        aligned_s;
    logic        stall_s;
    logic        misal_s;
    logic [31:0] rdout_s;

    assign acc_s     = mem_read_in | mem_write_in;
    assign aligned_s = (address_in[1:0] == 2'b00);

    // State and bus-side registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            both_q  <= 1'b0;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            rdata_q <= 32'h0000_0000;
            cnt_q   <= 8'd0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            both_q  <= both_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state logic and combinational pipeline-side outputs
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        both_d  = both_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        stall_s = 1'b0;
        misal_s = 1'b0;
        rdout_s = 32'h0000_0000;
        case (state_q)
            ST_IDLE: begin
                if (acc_s && aligned_s) begin
                    stall_s = 1'b1;
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    we_d    = mem_write_in;
                    both_d  = mem_read_in & mem_write_in;
                    addr_d  = {address_in[31:2], 2'b00};
                    wdata_d = write_data_in;
                    cnt_d   = 8'd0;
                end else if (acc_s) begin
                    misal_s = 1'b1;
                    rdout_s = ERR_DATA;
                end else begin
                    rdout_s = 32'h0000_0000;
                end
            end
            ST_REQ: begin
                stall_s = 1'b1;
                // Ack wins over expiry when both land on the same edge
                if (bus_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                    if (!we_q) begin
                        rdata_d = bus_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (cnt_q == LAST_CNT) begin
                    req_d   = 1'b0;
                    rdata_d = ERR_DATA;
                    tmo_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                tmo_d   = 1'b0;
                if (both_q) begin
                    rdout_s = ERR_DATA;
                end else if (we_q) begin
                    rdout_s = 32'h0000_0000;
                end else begin
                    rdout_s = rdata_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                tmo_d   = 1'b0;
            end
        endcase
    end

    // Stall drops with reset itself so a held request cannot freeze the pipe
    assign mem_stall     = stall_s & rst;
    assign misaligned    = misal_s;
    assign read_data_out = rdout_s;
    assign bus_timeout   = tmo_q;
    assign bus_req       = req_q;
    assign bus_we        = we_q;
    assign bus_addr      = addr_q;
    assign bus_wdata     = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit: bench drives the memory
// side by hand and compares against hand-computed cycle counts and data.
module tb_mem_access_unit;

    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [31:0] address_in;
    logic [31:0] write_data_in;
    logic [31:0] read_data_out;
    logic        mem_stall;
    logic        misaligned;
    logic        bus_timeout;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    int          st_n, rq_n, to_n, unstable, done_cyc, prev_cyc;
    logic [31:0] done_data;

    mem_access_unit #(.MAX_WAIT(15), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst(rst),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .address_in(address_in), .write_data_in(write_data_in),
        .read_data_out(read_data_out), .mem_stall(mem_stall),
        .misaligned(misaligned), .bus_timeout(bus_timeout),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // One access from the IDLE detect cycle through DONE; memory acks in REQ cycle ack_at (-1 = never)
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input int ack_at, input logic [31:0] rdata);
        int   guard;
        logic done;
        st_n = 0; rq_n = 0; to_n = 0; unstable = 0; done = 1'b0; guard = 0;
        @(negedge clk);
        mem_read_in = rd; mem_write_in = wr; address_in = addr; write_data_in = wdata;
        bus_ack = 1'b0;
        while (!done && guard < 40) begin
            #1;
            if (bus_timeout) to_n++;
            if (bus_req) begin
                rq_n++;
                if (bus_addr !== {addr[31:2], 2'b00} || bus_we !== wr || (wr && bus_wdata !== wdata))
                    unstable++;
                if (rq_n - 1 == ack_at) begin
                    bus_ack = 1'b1;
                    bus_rdata = rdata;
                end
            end
            if (!mem_stall) begin
                done = 1'b1;
                done_data = read_data_out;
                done_cyc = cyc;
            end else begin
                st_n++;
                @(negedge clk);
                bus_ack = 1'b0;
                guard++;
            end
        end
        if (!done) check("access_bound", 32'd0, 32'd1);
        mem_read_in = 1'b0; mem_write_in = 1'b0; bus_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        address_in = 32'd0; write_data_in = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
        #2;
        check("rst_req", 32'(bus_req), 32'd0);
        check("rst_we", 32'(bus_we), 32'd0);
        check("rst_addr", bus_addr, 32'd0);
        check("rst_wdata", bus_wdata, 32'd0);
        check("rst_stall", 32'(mem_stall), 32'd0);
        check("rst_tmo", 32'(bus_timeout), 32'd0);
        check("rst_rdata", read_data_out, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        // lw 1000, ack in third REQ cycle
        do_access(1'b1, 1'b0, 32'd1000, 32'd0, 2, 32'd110);
        check("lw_reqs", 32'(rq_n), 32'd3);
        check("lw_stalls", 32'(st_n), 32'd4);
        check("lw_data", done_data, 32'd110);
        check("lw_stable", 32'(unstable), 32'd0);
        check("lw_tmo", 32'(to_n), 32'd0);

        // sw, ack in first REQ cycle
        do_access(1'b0, 1'b1, 32'd4, 32'h1234_5678, 0, 32'hFFFF_FFFF);
        check("sw_reqs", 32'(rq_n), 32'd1);
        check("sw_stalls", 32'(st_n), 32'd2);
        check("sw_data", done_data, 32'd0);
        check("sw_stable", 32'(unstable), 32'd0);

        // misaligned lw
        @(negedge clk);
        mem_read_in = 1'b1; address_in = 32'd1002;
        #1;
        check("mis_flag", 32'(misaligned), 32'd1);
        check("mis_stall", 32'(mem_stall), 32'd0);
        check("mis_data", read_data_out, ERR);
        @(negedge clk);
        #1;
        check("mis_noreq", 32'(bus_req), 32'd0);
        mem_read_in = 1'b0;
        #1;
        check("idle_mis", 32'(misaligned), 32'd0);
        check("idle_data", read_data_out, 32'd0);

        // lw with no ack -> timeout
        do_access(1'b1, 1'b0, 32'd64, 32'd0, -1, 32'd0);
        check("to_reqs", 32'(rq_n), 32'd15);
        check("to_stalls", 32'(st_n), 32'd16);
        check("to_pulse", 32'(to_n), 32'd1);
        check("to_data", done_data, ERR);
        @(negedge clk);
        #1;
        check("to_clear", 32'(bus_timeout), 32'd0);
        check("to_idle_req", 32'(bus_req), 32'd0);

        // ack coincident with expiry counts as success
        do_access(1'b1, 1'b0, 32'd128, 32'd0, 14, 32'd55);
        check("exp_ack_reqs", 32'(rq_n), 32'd15);
        check("exp_ack_tmo", 32'(to_n), 32'd0);
        check("exp_ack_data", done_data, 32'd55);

        // lw+sw together: write on the bus, error data returned
        do_access(1'b1, 1'b1, 32'd16, 32'hA5A5_0000, 0, 32'd9);
        check("both_stable", 32'(unstable), 32'd0);
        check("both_data", done_data, ERR);

        // asynchronous reset in REQ cycle 2
        @(negedge clk);
        mem_read_in = 1'b1; address_in = 32'd8;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre_rst_req", 32'(bus_req), 32'd1);
        rst = 1'b0;
        #1;
        check("arst_req", 32'(bus_req), 32'd0);
        check("arst_stall", 32'(mem_stall), 32'd0);
        mem_read_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        do_access(1'b1, 1'b0, 32'd12, 32'd0, 1, 32'd77);
        check("post_rst_stalls", 32'(st_n), 32'd3);
        check("post_rst_data", done_data, 32'd77);

        // spurious ack in IDLE, then back-to-back loads
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        check("spur_req", 32'(bus_req), 32'd0);
        check("spur_stall", 32'(mem_stall), 32'd0);
        check("spur_data", read_data_out, 32'd0);
        do_access(1'b1, 1'b0, 32'd0, 32'd0, 0, 32'h0000_1111);
        check("b2b_a_data", done_data, 32'h0000_1111);
        prev_cyc = done_cyc;
        do_access(1'b1, 1'b0, 32'd4, 32'd0, 0, 32'h0000_2222);
        check("b2b_b_data", done_data, 32'h0000_2222);
        check("b2b_b_stalls", 32'(st_n), 32'd2);
        check("b2b_gap", 32'(done_cyc - prev_cyc), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage initiator for the pipelined MIPS core. It turns the stage's lw/sw control (mem_read, mem_write, address, write data) into a req/ack transaction toward a variable-latency data memory.
- It holds the whole pipeline with mem_stall until the memory responds, then presents load data for exactly one advancing cycle.
- It also flags misaligned word accesses and bus timeouts.

Parameters:
- MAX_WAIT, 15: maximum REQ cycles without bus_ack before the transaction is abandoned (legal range 1..255).
- ERR_DATA, 32'h0000_0000: value returned on read_data_out for a timed-out or misaligned load.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- mem_read_in  input  1  MEM-stage load request (lw).
- mem_write_in  input  1  MEM-stage store request (sw).
- address_in  input  32  byte address from the EX/MEM ALU result.
- write_data_in  input  32  store data, big-endian word.
- read_data_out  output  32  load data to MEM/WB; valid in the DONE cycle.
- mem_stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM; 1 = hold.
- misaligned  output  1  access with address_in[1:0] != 0; combinational, one cycle.
- bus_timeout  output  1  one-cycle pulse in DONE when MAX_WAIT expired.
- bus_req  output  1  request to memory, registered.
- bus_we  output  1  1 = write, 0 = read; registered.
- bus_addr  output  32  word address, registered.
- bus_wdata  output  32  write data, registered.
- bus_ack  input  1  memory completion, sampled on rising clk while bus_req = 1.
- bus_rdata  input  32  read data, valid when bus_ack = 1 and bus_we = 0.

Behaviour:
- Reset (rst = 0, asynchronous, any state):
  - state = IDLE.
  - bus_req, bus_we = 0; bus_addr, bus_wdata = 0.
  - wait counter = 0; captured rdata = 0; bus_timeout = 0.
  - Combinational outputs follow from IDLE.
  - A transaction in flight at reset is abandoned; the memory side must tolerate a dropped request.
- Access detection: acc = mem_read_in | mem_write_in. If both are asserted, the access is treated as a write; read_data_out = ERR_DATA.
- IDLE:
  - acc with aligned address:
    - mem_stall = 1 combinationally in the same cycle.
    - At the next edge: capture we = mem_write_in, address, write data; bus_req <= 1; counter <= 0; go to REQ.
  - acc with misaligned address:
    - misaligned = 1; mem_stall = 0; no bus transaction; read_data_out = ERR_DATA; stay in IDLE.
  - No acc: mem_stall = 0, read_data_out = 0.
- REQ:
  - mem_stall = 1; bus_req, bus_we, bus_addr, bus_wdata held stable.
  - bus_ack = 1 at an edge:
    - For a read, capture bus_rdata.
    - bus_req <= 0; go to DONE.
  - No ack:
    - counter increments.
    - When the counter reaches MAX_WAIT-1 with no ack: bus_req <= 0; captured rdata <= ERR_DATA; bus_timeout <= 1; go to DONE.
  - An ack on the same edge as expiry counts as success; ack has priority.
- DONE:
  - mem_stall = 0, so the pipeline advances at the end of this cycle.
  - read_data_out = captured rdata for a read, 0 for a write.
  - bus_timeout is asserted only in this cycle.
  - Next edge: go to IDLE unconditionally and clear bus_timeout.
  - The request inputs in DONE belong to the completing instruction and are ignored.
- Latency: an ack in the first REQ cycle gives 2 stall cycles (IDLE detect + REQ) followed by 1 DONE cycle. Each extra ack-wait cycle adds one stall cycle.
- bus_ack while bus_req = 0 (IDLE or DONE) is ignored.
- Width rules: bus_addr = {address_in[31:2], 2'b00}. The counter is 8 bits and does not wrap before expiry.
- Back-to-back accesses: the next lw/sw arrives in IDLE on the cycle after DONE; there is no bubble beyond the IDLE detect cycle.

Test Plan:
- Aligned lw at 32'd1000, memory acks 3 REQ cycles later with 32'd110 -> bus_req high for 3 cycles with bus_addr = 1000 and bus_we = 0; mem_stall high for 4 cycles; DONE cycle read_data_out = 110 and mem_stall = 0.
- sw of 32'h1234_5678 at address 4, ack in the first REQ cycle -> bus_we = 1 and bus_wdata = 32'h1234_5678 held stable; stall for exactly 2 cycles; read_data_out = 0 in DONE.
- lw at address 32'd1002 -> misaligned = 1 for the cycle; mem_stall = 0; bus_req never rises; read_data_out = ERR_DATA.
- lw with no ack, MAX_WAIT = 15 -> bus_req high for 15 cycles then drops; bus_timeout pulses once in DONE; read_data_out = ERR_DATA; return to IDLE.
- rst driven low mid-REQ (cycle 2 of the wait) -> bus_req = 0 and mem_stall = 0 immediately without a clock edge; after release, a new lw runs normally.
- Spurious bus_ack in IDLE, then back-to-back lw at 0 and lw at 4, each acked in the first REQ cycle -> the spurious ack causes no state change; the two reads return mem[0] and mem[4] in consecutive DONE cycles separated by exactly 2 stall cycles.
